// File: rtl/mac_accum_signed.sv
// mac_accum_signed: accumulates COUNT signed products into one ACC_W-bit
// frame sum and presents it on a valid/ready output port.
// Optional build macro: MAC_ACCUM_SATURATE_EN -- when defined, the running
// sum clamps at the signed ACC_W limits instead of wrapping. Overflow is
// reported per frame in both builds.
module mac_accum_signed #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int COUNT  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PROD_W-1:0]        product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     overflow,
  output logic [$clog2(COUNT)-1:0] beat_cnt
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

`ifdef MAC_ACCUM_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp an ACC_W+1-bit sum to the signed ACC_W range; the top bit gives
  // the true sign, so it selects which limit an out-of-range sum hits.
  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W:0] sum);
    logic [ACC_W-1:0] res;
    if (sum[ACC_W] ^ sum[ACC_W-1]) begin
      res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      res = sum[ACC_W-1:0];
    end
    return res;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W:0]   sum_s;
  logic             sum_ovf_s;
  logic [ACC_W-1:0] acc_next_s;

  // Extend both operands by one bit so the true sum is always representable.
  assign sum_s     = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
  assign sum_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];

  // Choose the stored accumulator value: clamped or two's-complement wrap.
  always_comb begin
`ifdef MAC_ACCUM_SATURATE_EN
    acc_next_s = sat_sum(sum_s);
`else
    acc_next_s = sum_s[ACC_W-1:0];
`endif
  end

  // Only accept products while collecting, and never in a clear cycle.
  assign in_ready = (state_q == ST_ACCUM) && !clear;

  // Next-state and datapath update for the collect / hold cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    frame_ovf_d = frame_ovf_q;
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_ACCUM: begin
        if (clear) begin
          acc_d       = {ACC_W{1'b0}};
          beat_cnt_d  = {CNT_W{1'b0}};
          frame_ovf_d = 1'b0;
        end else if (in_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            acc_out_d   = acc_next_s;
            overflow_d  = frame_ovf_q | sum_ovf_s;
            out_valid_d = 1'b1;
            acc_d       = {ACC_W{1'b0}};
            beat_cnt_d  = {CNT_W{1'b0}};
            frame_ovf_d = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d       = acc_next_s;
            beat_cnt_d  = beat_cnt_q + CNT_W'(1);
            frame_ovf_d = frame_ovf_q | sum_ovf_s;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        // clear is deliberately ignored here so the pending result survives.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_ACCUM;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= {ACC_W{1'b0}};
      beat_cnt_q  <= {CNT_W{1'b0}};
      frame_ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= {ACC_W{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_ovf_q <= frame_ovf_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign overflow  = overflow_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mac_accum_signed.sv
// Directed testbench for mac_accum_signed (PROD_W=16, ACC_W=20, COUNT=64).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mac_accum_signed;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int COUNT  = 64;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic [5:0]        beat_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mac_accum_signed #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .product(product), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .overflow(overflow),
    .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present n consecutive beats of value p, then drop in_valid; returns on
  // the falling edge right after the last accepting rising edge.
  task automatic send_beats(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      product  = 16'(p);
    end
    @(negedge clk);
    in_valid = 1'b0;
    product  = 16'h0000;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; product = 16'h0000; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'h00000) $display("FAIL reset_acc_out: got %0d expected 0", acc_out); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (beat_cnt !== 6'd0) $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic_frame;
    out_ready = 1'b1;
    send_beats(1, 63);
    total_cnt++; if (beat_cnt !== 6'd63) $display("FAIL basic_cnt63: got %0d expected 63", beat_cnt); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid); else pass_cnt++;
    send_beats(1, 1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd64) $display("FAIL basic_acc: got %0d expected 64", $signed(acc_out)); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_hold_ready: got %b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (beat_cnt !== 6'd0) $display("FAIL basic_cnt_wrap: got %0d expected 0", beat_cnt); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_mixed_signs;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); in_valid = 1'b1; product = 16'(16384);
      @(negedge clk); in_valid = 1'b1; product = 16'(-16256);
    end
    @(negedge clk); in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL mixed_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd4096) $display("FAIL mixed_acc: got %0d expected 4096", $signed(acc_out)); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL mixed_ovf: got %b expected 0", overflow); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_beats(-3, 64);
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); else pass_cnt++;
      total_cnt++; if (acc_out !== 20'(-192)) $display("FAIL bp_acc[%0d]: got %0d expected -192", c, $signed(acc_out)); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b expected 0", c, in_ready); else pass_cnt++;
      total_cnt++; if (beat_cnt !== 6'd0) $display("FAIL bp_cnt[%0d]: got %0d expected 0", c, beat_cnt); else pass_cnt++;
      in_valid = (c % 2 == 0) ? 1'b1 : 1'b0;
      product  = 16'(7);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid_release: got %b expected 1", out_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (beat_cnt !== 6'd0) $display("FAIL bp_no_stray_beats: got %0d expected 0", beat_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [ACC_W-1:0] exp_acc;
`ifdef MAC_ACCUM_SATURATE_EN
    exp_acc = 20'd524287;
`else
    exp_acc = 20'd0;
`endif
    out_ready = 1'b1;
    send_beats(16384, 64);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== exp_acc) $display("FAIL ovf_acc: got %0d expected %0d", $signed(acc_out), $signed(exp_acc)); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else pass_cnt++;
    send_beats(1, 64);
    total_cnt++; if (acc_out !== 20'd64) $display("FAIL ovf_next_acc: got %0d expected 64", $signed(acc_out)); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_next_flag: got %b expected 0", overflow); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    send_beats(100, 10);
    total_cnt++; if (beat_cnt !== 6'd10) $display("FAIL clr_cnt10: got %0d expected 10", beat_cnt); else pass_cnt++;
    clear = 1'b1; in_valid = 1'b1; product = 16'(100);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL clr_ready: got %b expected 0", in_ready); else pass_cnt++;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    total_cnt++; if (beat_cnt !== 6'd0) $display("FAIL clr_cnt0: got %0d expected 0", beat_cnt); else pass_cnt++;
    send_beats(-2, 64);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL clr_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'(-128)) $display("FAIL clr_acc: got %0d expected -128", $signed(acc_out)); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_clear_in_hold;
    out_ready = 1'b0;
    send_beats(5, 64);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_clr_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd320) $display("FAIL hold_clr_acc: got %0d expected 320", $signed(acc_out)); else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_clr_drop: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; product = 16'(1);
    repeat (64) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid1: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd64) $display("FAIL b2b_acc1: got %0d expected 64", $signed(acc_out)); else pass_cnt++;
    repeat (64) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_gap: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (beat_cnt !== 6'd63) $display("FAIL b2b_cnt63: got %0d expected 63", beat_cnt); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid2: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd64) $display("FAIL b2b_acc2: got %0d expected 64", $signed(acc_out)); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    out_ready = 1'b0;
    send_beats(3, 64);
    out_ready = 1'b1;
    @(negedge clk);
    send_beats(1, 20);
    total_cnt++; if (beat_cnt !== 6'd20) $display("FAIL rst_pre_cnt: got %0d expected 20", beat_cnt); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd192) $display("FAIL rst_pre_acc: got %0d expected 192", $signed(acc_out)); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd0) $display("FAIL rst_mid_acc: got %0d expected 0", $signed(acc_out)); else pass_cnt++;
    total_cnt++; if (beat_cnt !== 6'd0) $display("FAIL rst_mid_cnt: got %0d expected 0", beat_cnt); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    send_beats(1, 64);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_after_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (acc_out !== 20'd64) $display("FAIL rst_after_acc: got %0d expected 64", $signed(acc_out)); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mixed_signs();
    test_backpressure();
    test_overflow();
    test_clear();
    test_clear_in_hold();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_accum_signed.md
Name: mac_accum_signed

Overview:
- Downstream consumer of the 8x8 signed multiplier's 16-bit signed product.
- Accumulates COUNT consecutive products into one signed sum (dot-product / FIR tap sum), then presents that sum on a valid/ready output port.
- Registered, single clock domain; sits between the combinational multiplier and the result sink.

Parameters:
PROD_W, 16, width of the signed input product
ACC_W, 20, width of the signed accumulator and result; must be > PROD_W
COUNT, 64, products per frame; must be >= 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort of the partial frame
in_valid  input  1  product is valid
in_ready  output  1  block accepts a product this cycle
product  input  PROD_W  signed product from multiplier
out_valid  output  1  frame result is valid
out_ready  input  1  sink accepts result
acc_out  output  ACC_W  signed frame sum
overflow  output  1  sum exceeded the ACC_W signed range during this frame; qualified by out_valid
beat_cnt  output  clog2(COUNT)  products accepted in the current frame

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, acc=0, beat_cnt=0, out_valid=0, acc_out=0, overflow=0. All are cleared immediately, including mid-frame; the partial frame is lost.
- States:
  - ACCUM: collecting products.
  - HOLD: result pending on the output port.
- in_ready = (state==ACCUM) && !clear. It is combinational from state and clear only; it never depends on in_valid.
- Beat = in_valid && in_ready.
  - product is sign-extended to ACC_W+1 bits and added to acc.
  - beat_cnt increments on every beat.
  - The per-frame overflow flag is set when the ACC_W+1-bit sum falls outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Final beat (beat_cnt==COUNT-1 at the beat):
  - acc_out <= new sum; overflow <= frame flag including this beat; out_valid <= 1.
  - acc, beat_cnt and the frame flag are reset to 0; state -> HOLD.
  - Latency: result is visible the cycle after the final beat.
- HOLD:
  - in_ready=0.
  - acc_out, overflow and out_valid stay stable until out_valid && out_ready.
  - On that output handshake: out_valid <= 0, state -> ACCUM. The next beat can be accepted the following cycle.
  - Maximum throughput is one frame per COUNT+1 cycles with out_ready tied high.
- clear (ACCUM): acc, beat_cnt and the frame flag <= 0. No beat is taken that cycle because in_ready is low.
- clear (HOLD): no effect; the pending result is preserved.
- in_valid with no beat: no state change. The product value is don't-care when in_valid=0.
- out_ready while out_valid=0: ignored.
- beat_cnt never reaches COUNT; it wraps to 0 on the final beat.

Optional Feature:
- Macro MAC_ACCUM_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative). Later beats add to the clamped value and clamp again. overflow is still reported.
- Undefined: two's-complement wrap modulo 2^ACC_W. overflow is still reported (sticky per frame).

Test Plan:
- Basic frame: 64 beats of product=+1 with out_ready=1 -> acc_out=64, overflow=0, out_valid high exactly the cycle after beat 64 for one cycle; in_ready low in that cycle.
- Mixed signs: 32 pairs of +16384 / -16256 -> acc_out=4096, overflow=0.
- Backpressure: complete a frame of 64 x (-3) with out_ready=0 for 5 cycles -> acc_out=-192 held stable, out_valid=1, in_ready=0, in_valid pulses ignored; after out_ready=1, in_ready rises the next cycle.
- Overflow: 64 x +16384.
  - With MAC_ACCUM_SATURATE_EN: acc_out=524287, overflow=1.
  - Without it: acc_out=0 (wrapped), overflow=1.
  - The next frame of 64 x +1 gives 64 with overflow=0.
- Clear: 10 beats of +100, clear pulse, then 64 beats of -2 -> acc_out=-128. A beat presented in the clear cycle is not counted.
- Reset mid-frame: after 20 beats pulse rst_n low asynchronously (between edges) -> in the same cycle out_valid=0, acc_out=0, beat_cnt=0; a subsequent 64 x +1 frame yields 64.
